// File: rtl/result_demux_32x3.sv
// 1:3 result demultiplexer: one-entry slot per consumer, valid/ready on both sides.
// Define DEMUX_STATS_EN to build per-destination delivery and drop counters.
module result_demux_32x3 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic [2:0]       out_valid,
  input  logic [2:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic             drop,
  output logic [CNT_W-1:0] cnt_out0,
  output logic [CNT_W-1:0] cnt_out1,
  output logic [CNT_W-1:0] cnt_out2,
  output logic [CNT_W-1:0] cnt_drop
);

  // Handshake: a word moves on any side exactly in a cycle where valid & ready are
  // both high at the rising edge; valid never waits on ready, and a slot's
  // out_valid/out_data hold steady until its consumer raises ready.

  logic [2:0]       full;
  logic [WIDTH-1:0] data_q [3];
  logic             accept;
  logic             accept_drop;

  // Only the addressed slot gates in_ready, so one stalled sink never blocks the others.
  always_comb begin
    in_ready = 1'b1;
    case (in_sel)
      2'd0:    in_ready = !full[0] | out_ready[0];
      2'd1:    in_ready = !full[1] | out_ready[1];
      2'd2:    in_ready = !full[2] | out_ready[2];
      default: in_ready = 1'b1;
    endcase
  end

  assign accept      = in_valid & in_ready;
  assign accept_drop = accept & (in_sel == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 3'b000;
      drop <= 1'b0;
      for (int k = 0; k < 3; k++) data_q[k] <= '0;
    end else begin
      drop <= accept_drop;
      for (int k = 0; k < 3; k++) begin
        if (accept && (in_sel == 2'(k))) begin
          full[k]   <= 1'b1;
          data_q[k] <= in_data;
        end else if (out_ready[k]) begin
          full[k] <= 1'b0;
        end
      end
    end
  end

  assign out_valid = full;
  assign out_data0 = data_q[0];
  assign out_data1 = data_q[1];
  assign out_data2 = data_q[2];

`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] cnt_q [4];

  // Counters wrap naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (full[k] && out_ready[k]) cnt_q[k] <= cnt_q[k] + CNT_W'(1);
      end
      if (accept_drop) cnt_q[3] <= cnt_q[3] + CNT_W'(1);
    end
  end

  assign cnt_out0 = cnt_q[0];
  assign cnt_out1 = cnt_q[1];
  assign cnt_out2 = cnt_q[2];
  assign cnt_drop = cnt_q[3];
`else
  assign cnt_out0 = '0;
  assign cnt_out1 = '0;
  assign cnt_out2 = '0;
  assign cnt_drop = '0;
`endif

endmodule

// File: tb/tb_result_demux_32x3.sv
// Directed bench for result_demux_32x3 (CNT_W=4 so counter wrap is reachable).
module tb_result_demux_32x3;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;
`ifdef DEMUX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_sel;
  logic [WIDTH-1:0] in_data;
  logic [2:0]       out_valid;
  logic [2:0]       out_ready;
  logic [WIDTH-1:0] out_data0;
  logic [WIDTH-1:0] out_data1;
  logic [WIDTH-1:0] out_data2;
  logic             drop;
  logic [CNT_W-1:0] cnt_out0;
  logic [CNT_W-1:0] cnt_out1;
  logic [CNT_W-1:0] cnt_out2;
  logic [CNT_W-1:0] cnt_drop;

  int checks;
  int failures;

  result_demux_32x3 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2),
    .drop(drop),
    .cnt_out0(cnt_out0), .cnt_out1(cnt_out1), .cnt_out2(cnt_out2), .cnt_drop(cnt_drop)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking task
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: advance one edge, then settle 1 time unit before sampling/driving
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic valid, input logic [1:0] sel, input logic [31:0] data);
    in_valid = valid;
    in_sel   = sel;
    in_data  = data;
    #1;
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
    return STATS ? 32'(n % (1 << CNT_W)) : 32'd0;
  endfunction

  task automatic check_counters(input string tag, input int c0, input int c1, input int c2, input int cd);
    check({tag, "_cnt0"}, 32'(cnt_out0), exp_cnt(c0));
    check({tag, "_cnt1"}, 32'(cnt_out1), exp_cnt(c1));
    check({tag, "_cnt2"}, 32'(cnt_out2), exp_cnt(c2));
    check({tag, "_cntd"}, 32'(cnt_drop), exp_cnt(cd));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    out_ready = 3'b000;
    drive(1'b0, 2'd0, 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // reset state
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_data0", out_data0, 32'h0);
    check("rst_data1", out_data1, 32'h0);
    check("rst_data2", out_data2, 32'h0);
    check("rst_drop", 32'(drop), 32'h0);
    check("rst_ready", 32'(in_ready), 32'h1);
    check_counters("rst", 0, 0, 0, 0);

    // basic routing
    out_ready = 3'b111;
    drive(1'b1, 2'd0, 32'hA000_0000);
    check("rt_ready0", 32'(in_ready), 32'h1);
    tick();
    check("rt_valid0", 32'(out_valid), 32'h1);
    check("rt_data0", out_data0, 32'hA000_0000);
    drive(1'b1, 2'd1, 32'hB111_1111);
    check("rt_ready1", 32'(in_ready), 32'h1);
    tick();
    check("rt_valid1", 32'(out_valid), 32'h2);
    check("rt_data1", out_data1, 32'hB111_1111);
    drive(1'b1, 2'd2, 32'hC222_2222);
    check("rt_ready2", 32'(in_ready), 32'h1);
    tick();
    check("rt_valid2", 32'(out_valid), 32'h4);
    check("rt_data2", out_data2, 32'hC222_2222);
    drive(1'b0, 2'd0, 32'h0);
    tick();
    check("rt_idle", 32'(out_valid), 32'h0);
    check_counters("rt", 1, 1, 1, 0);

    // backpressure on slot 1
    out_ready = 3'b101;
    drive(1'b1, 2'd1, 32'h11);
    check("bp_ready_a", 32'(in_ready), 32'h1);
    tick();
    check("bp_valid_a", 32'(out_valid), 32'h2);
    check("bp_data_a", out_data1, 32'h11);
    drive(1'b1, 2'd1, 32'h22);
    check("bp_ready_b", 32'(in_ready), 32'h0);
    tick();
    check("bp_hold_valid", 32'(out_valid), 32'h2);
    check("bp_hold_data", out_data1, 32'h11);
    out_ready = 3'b111;
    #1;
    check("bp_ready_c", 32'(in_ready), 32'h1);
    tick();
    check("bp_valid_b", 32'(out_valid), 32'h2);
    check("bp_data_b", out_data1, 32'h22);
    drive(1'b0, 2'd0, 32'h0);
    tick();
    check("bp_idle", 32'(out_valid), 32'h0);
    check_counters("bp", 1, 3, 1, 0);

    // isolation: slot 2 stalled must not block slot 0
    out_ready = 3'b011;
    drive(1'b1, 2'd2, 32'h99);
    tick();
    check("iso_valid_a", 32'(out_valid), 32'h4);
    drive(1'b1, 2'd2, 32'h98);
    check("iso_block2", 32'(in_ready), 32'h0);
    drive(1'b1, 2'd0, 32'h5);
    check("iso_ready0", 32'(in_ready), 32'h1);
    tick();
    check("iso_valid_b", 32'(out_valid), 32'h5);
    check("iso_data0", out_data0, 32'h5);
    check("iso_data2", out_data2, 32'h99);
    drive(1'b0, 2'd0, 32'h0);
    tick();
    check("iso_valid_c", 32'(out_valid), 32'h4);
    check("iso_data2_b", out_data2, 32'h99);

    // illegal select
    drive(1'b1, 2'd3, 32'hDEAD);
    check("ill_ready", 32'(in_ready), 32'h1);
    tick();
    check("ill_drop", 32'(drop), 32'h1);
    check("ill_valid", 32'(out_valid), 32'h4);
    check("ill_data0", out_data0, 32'h5);
    drive(1'b0, 2'd0, 32'h0);
    tick();
    check("ill_drop_end", 32'(drop), 32'h0);
    check_counters("ill", 2, 3, 1, 1);

    // reset mid-operation with all slots full
    out_ready = 3'b000;
    drive(1'b1, 2'd0, 32'h1);
    tick();
    drive(1'b1, 2'd1, 32'h2);
    tick();
    drive(1'b0, 2'd0, 32'h0);
    check("mid_full", 32'(out_valid), 32'h7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_valid", 32'(out_valid), 32'h0);
    check("mid_data0", out_data0, 32'h0);
    check("mid_data2", out_data2, 32'h0);
    check("mid_drop", 32'(drop), 32'h0);
    check_counters("mid", 0, 0, 0, 0);
    out_ready = 3'b111;
    drive(1'b1, 2'd2, 32'h7);
    check("mid_ready", 32'(in_ready), 32'h1);
    tick();
    check("mid_valid2", 32'(out_valid), 32'h4);
    check("mid_data2b", out_data2, 32'h7);
    drive(1'b0, 2'd0, 32'h0);
    tick();
    check_counters("post", 0, 0, 1, 0);

    // 17 back-to-back deliveries on out0; counter wraps at 16
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 2'd0, 32'h100 + 32'(i));
      check("wr_ready", 32'(in_ready), 32'h1);
      tick();
      check("wr_data", out_data0, 32'h100 + 32'(i));
    end
    drive(1'b0, 2'd0, 32'h0);
    tick();
    check("wr_idle", 32'(out_valid), 32'h0);
    check_counters("wr", 17, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
